// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: glyph patterns (active-high,
// {g,f,e,d,c,b,a}), scan FSM encoding, digit count and a leading-zero helper.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_t;

   // True when digit k and every more-significant digit are zero (k = 0 never blanks).
   function automatic logic lzb_blank(input logic [15:0] bcd, input logic [1:0] k);
      logic res;
      case (k)
         2'd1:    res = (bcd[15:4]  == 12'h000);
         2'd2:    res = (bcd[15:8]  == 8'h00);
         2'd3:    res = (bcd[15:12] == 4'h0);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment glyph; non-BCD codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   // Glyph lookup
   always_comb begin
      pattern = SEG_DASH;
      case (nibble)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner: per-frame snapshot, leading-zero blanking,
// inter-digit guard time and fully registered pin outputs.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_TICKS     = 2,
   parameter int ANODE_ACT_LOW   = 1,
   parameter int SEG_ACT_LOW     = 1,
   parameter int LZB_EN          = 1
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [15:0] i_BCD,
   input  logic        i_bcd_valid,
   input  logic [3:0]  i_dp,
   output logic [6:0]  o_seg,
   output logic        o_dp,
   output logic [3:0]  o_anode,
   output logic        o_frame_start
);

   localparam int PRE_W = $clog2(TICKS_PER_DIGIT);
   localparam int GRD_W = $clog2(BLANK_TICKS + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_DIGIT - 1);
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(BLANK_TICKS - 1);
   localparam logic ANODE_LOW = (ANODE_ACT_LOW != 0);
   localparam logic SEG_LOW   = (SEG_ACT_LOW != 0);
   localparam logic LZB_ON    = (LZB_EN != 0);

   scan_state_t      state_r, state_s;
   logic [1:0]       idx_r, idx_s;
   logic [PRE_W-1:0] pre_r, pre_s;
   logic [GRD_W-1:0] grd_r, grd_s;
   logic [19:0]      pending_r, pending_s;
   logic [19:0]      active_r, active_s;
   logic [6:0]       seg_r, seg_s;
   logic             dp_r, dp_s;
   logic [3:0]       anode_r, anode_s;
   logic             frame_start_r, frame_start_s;
   logic [3:0]       nibble_s;
   logic [3:0]       dp_word_s;
   logic [6:0]       pattern_s;
   logic             blank_s;

   bcd_to_seg7 u_dec (
      .nibble  (nibble_s),
      .pattern (pattern_s)
   );

   // Next-state logic for the scan FSM and its counters
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      pre_s   = pre_r;
      grd_s   = grd_r;
      if (!i_en) begin
         state_s = ST_IDLE;
         idx_s   = 2'd0;
         pre_s   = '0;
         grd_s   = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_DRIVE;
               idx_s   = 2'd0;
               pre_s   = '0;
            end
            ST_DRIVE: begin
               if (pre_r == PRE_LAST) begin
                  state_s = ST_BLANK;
                  pre_s   = '0;
                  grd_s   = '0;
                  idx_s   = (idx_r == 2'd3) ? 2'd0 : idx_r + 2'd1;
               end else begin
                  pre_s = pre_r + 1'b1;
               end
            end
            ST_BLANK: begin
               if (grd_r == GRD_LAST) begin
                  state_s = ST_DRIVE;
                  grd_s   = '0;
               end else begin
                  grd_s = grd_r + 1'b1;
               end
            end
            default: begin
               state_s = ST_IDLE;
               idx_s   = 2'd0;
               pre_s   = '0;
               grd_s   = '0;
            end
         endcase
      end
   end

   // Snapshot registers and next pin values; a strobe on the frame-start cycle writes through
   always_comb begin
      frame_start_s = (state_s == ST_DRIVE) && (state_r != ST_DRIVE) && (idx_s == 2'd0);
      pending_s     = i_bcd_valid ? {i_dp, i_BCD} : pending_r;
      active_s      = frame_start_s ? pending_s : active_r;
      nibble_s      = active_s[{idx_s, 2'b00} +: 4];
      dp_word_s     = active_s[19:16];
      blank_s       = LZB_ON && lzb_blank(active_s[15:0], idx_s);
      if (state_s == ST_DRIVE) begin
         anode_s = (4'b0001 << idx_s) ^ {4{ANODE_LOW}};
         seg_s   = (blank_s ? SEG_OFF : pattern_s) ^ {7{SEG_LOW}};
         dp_s    = dp_word_s[idx_s] ^ SEG_LOW;
      end else begin
         anode_s = {4{ANODE_LOW}};
         seg_s   = {7{SEG_LOW}};
         dp_s    = SEG_LOW;
      end
   end

   // State, counters and snapshot registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r   <= ST_IDLE;
         idx_r     <= 2'd0;
         pre_r     <= '0;
         grd_r     <= '0;
         pending_r <= 20'h00000;
         active_r  <= 20'h00000;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         pre_r     <= pre_s;
         grd_r     <= grd_s;
         pending_r <= pending_s;
         active_r  <= active_s;
      end
   end

   // Registered pin drivers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         anode_r       <= {4{ANODE_LOW}};
         seg_r         <= {7{SEG_LOW}};
         dp_r          <= SEG_LOW;
         frame_start_r <= 1'b0;
      end else begin
         anode_r       <= anode_s;
         seg_r         <= seg_s;
         dp_r          <= dp_s;
         frame_start_r <= frame_start_s;
      end
   end

   assign o_seg         = seg_r;
   assign o_dp          = dp_r;
   assign o_anode       = anode_r;
   assign o_frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed literal checks plus randomized traffic compared every
// cycle against a frame-position model of the display.
module tb_seg7_scan_ctrl;

   localparam int T     = 4;
   localparam int B     = 1;
   localparam int SLOT  = T + B;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] bcd = 16'h0000;
   logic        valid = 1'b0;
   logic [3:0]  dp = 4'h0;
   logic [6:0]  o_seg;
   logic        o_dp;
   logic [3:0]  o_anode;
   logic        o_frame_start;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   bit          m_run;
   int          m_pos;
   logic [19:0] m_pend;
   logic [19:0] m_act;

   seg7_scan_ctrl #(
      .TICKS_PER_DIGIT (T),
      .BLANK_TICKS     (B),
      .ANODE_ACT_LOW   (1),
      .SEG_ACT_LOW     (1),
      .LZB_EN          (1)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_BCD         (bcd),
      .i_bcd_valid   (valid),
      .i_dp          (dp),
      .o_seg         (o_seg),
      .o_dp          (o_dp),
      .o_anode       (o_anode),
      .o_frame_start (o_frame_start)
   );

   always #5 clk = ~clk;

   // Active-low glyphs {g,f,e,d,c,b,a}
   function automatic logic [6:0] glyph(input int n);
      case (n)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // {frame_start, dp, anode, seg} the pins must show at a given frame position
   function automatic logic [12:0] expect_pins(input bit run, input int pos, input logic [19:0] act);
      int slot, off, upper, nib;
      logic [6:0] seg;
      logic [3:0] an;
      if (!run) return {1'b0, 1'b1, 4'b1111, 7'h7F};
      slot = pos / SLOT;
      off  = pos % SLOT;
      if (off >= T) return {1'b0, 1'b1, 4'b1111, 7'h7F};
      upper = int'(act[15:0]) >> (4 * slot);
      nib   = upper % 16;
      seg   = (slot > 0 && upper == 0) ? 7'h7F : glyph(nib);
      an    = 4'b1111;
      an[slot] = 1'b0;
      return {(pos == 0), ~act[16 + slot], an, seg};
   endfunction

   // Behavioural model: frame position since enable, plus the two snapshot words
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  <= 1'b0;
         m_pos  <= 0;
         m_pend <= 20'h0;
         m_act  <= 20'h0;
      end else begin
         m_pend <= valid ? {dp, bcd} : m_pend;
         if (!en) begin
            m_run <= 1'b0;
            m_pos <= 0;
         end else if (!m_run) begin
            m_run <= 1'b1;
            m_pos <= 0;
            m_act <= valid ? {dp, bcd} : m_pend;
         end else begin
            m_pos <= (m_pos + 1) % FRAME;
            if ((m_pos + 1) % FRAME == 0) m_act <= valid ? {dp, bcd} : m_pend;
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [12:0] e;
      if (chk_en) begin
         e = expect_pins(m_run, m_pos, m_act);
         check("model_anode", {4'h0, o_anode}, {4'h0, e[10:7]});
         check("model_seg", {1'b0, o_seg}, {1'b0, e[6:0]});
         check("model_dp", {7'h0, o_dp}, {7'h0, e[11]});
         check("model_fs", {7'h0, o_frame_start}, {7'h0, e[12]});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_fs();
      bit found = 1'b0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         @(negedge clk);
         if (o_frame_start === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_frame_start actual=timeout required=pulse at %0t", $time);
      end
   endtask

   task automatic pins(input string name, input logic [3:0] an, input logic [6:0] seg);
      check({name, "_anode"}, {4'h0, o_anode}, {4'h0, an});
      check({name, "_seg"}, {1'b0, o_seg}, {1'b0, seg});
   endtask

   initial begin
      int en_off;
      logic [31:0] r;
      step(1);
      chk_en = 1'b1;
      step(2);
      rst = 1'b0;
      step(3);
      pins("reset", 4'b1111, 7'h7F);
      check("reset_dp", {7'h0, o_dp}, 8'h01);
      check("reset_fs", {7'h0, o_frame_start}, 8'h00);

      // 1234 scan order and timing
      bcd = 16'h1234; dp = 4'h0; valid = 1'b1;
      step(1);
      valid = 1'b0; en = 1'b1;
      step(1);
      pins("d0_4", 4'b1110, 7'b0011001);
      check("d0_fs", {7'h0, o_frame_start}, 8'h01);
      step(4);  pins("guard", 4'b1111, 7'h7F);
      step(1);  pins("d1_3", 4'b1101, 7'b0110000);
      step(5);  pins("d2_2", 4'b1011, 7'b0100100);
      step(5);  pins("d3_1", 4'b0111, 7'b1111001);
      step(5);  check("fs_period", {7'h0, o_frame_start}, 8'h01);

      // Leading-zero blanking
      bcd = 16'h0034; valid = 1'b1;
      step(1);
      valid = 1'b0;
      wait_fs();
      step(10); pins("lzb_d2", 4'b1011, 7'h7F);
      step(5);  pins("lzb_d3", 4'b0111, 7'h7F);
      bcd = 16'h0000; valid = 1'b1;
      step(1);
      valid = 1'b0;
      wait_fs();
      pins("zero_d0", 4'b1110, 7'b1000000);
      step(5);  pins("zero_d1", 4'b1101, 7'h7F);

      // Mid-frame update is deferred to the next frame
      bcd = 16'h5678; valid = 1'b1;
      step(1);
      valid = 1'b0;
      step(4);  pins("defer_d2", 4'b1011, 7'h7F);
      wait_fs();
      pins("next_d0_8", 4'b1110, 7'b0000000);

      // Write-through on the frame-start cycle
      step(19);
      bcd = 16'h00A0; dp = 4'b0010; valid = 1'b1;
      step(1);
      valid = 1'b0;
      pins("wt_d0", 4'b1110, 7'b1000000);
      check("wt_dp0", {7'h0, o_dp}, 8'h01);
      step(5);
      pins("wt_dash", 4'b1101, 7'b0111111);
      check("wt_dp1", {7'h0, o_dp}, 8'h00);

      // Enable drop during digit 2
      wait_fs();
      step(10);
      en = 1'b0;
      step(1);  pins("en_off", 4'b1111, 7'h7F);
      step(3);  pins("en_hold", 4'b1111, 7'h7F);
      en = 1'b1;
      step(1);
      pins("reen", 4'b1110, 7'b1000000);
      check("reen_fs", {7'h0, o_frame_start}, 8'h01);

      // Asynchronous reset mid-DRIVE
      step(2);
      #2 rst = 1'b1;
      #1;
      pins("arst", 4'b1111, 7'h7F);
      check("arst_dp", {7'h0, o_dp}, 8'h01);
      check("arst_fs", {7'h0, o_frame_start}, 8'h00);
      step(2);
      rst = 1'b0;

      // Randomized traffic
      en_off = 0;
      for (int c = 0; c < 2000; c++) begin
         r = $urandom;
         valid = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: bcd = {12'h000, r[3:0]};
            1: bcd = {8'h00, r[7:0]};
            2: bcd = {4'h0, r[11:0]};
            default: bcd = r[15:0];
         endcase
         dp = r[19:16];
         if (en_off > 0) en_off--;
         else if ($urandom_range(0, 99) == 0) en_off = $urandom_range(1, 6);
         en = (en_off == 0);
         step(1);
      end
      valid = 1'b0;
      step(2);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
